// File: rtl/decode_queue_if.sv
// Handshake and data bundle between IF, the decode queue and ID.
// The queue takes the slave view; the IF/ID side takes the master view.
interface decode_queue_if #(
    parameter int PC_W    = 32,
    parameter int CLASS_W = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        in_instr;
    logic [PC_W-1:0]    in_pc;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_instr;
    logic [PC_W-1:0]    out_pc;
    logic [CLASS_W-1:0] out_class;
    logic               out_ri;
    logic               out_use_rs;
    logic               out_use_rt;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_class,
               out_ri, out_use_rs, out_use_rt
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_class,
               out_ri, out_use_rs, out_use_rt
    );
endinterface

// File: rtl/decode_queue.sv
// IF->ID decode buffer: decodes each instruction at enqueue and holds it in a DEPTH-entry FIFO.
// Optional saturating RI dequeue counter enabled by DECODE_QUEUE_RI_STATS_EN.
module decode_queue #(
    parameter int DEPTH   = 4,
    parameter int PC_W    = 32,
    parameter int CLASS_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    decode_queue_if.slave          bus,
    output logic [$clog2(DEPTH):0] count,
    output logic [31:0]            ri_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [31:0] ERET_WORD = 32'h4200_0018;

    localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J    = 6'h02, OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04, OP_BNE    = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI    = 6'h08, OP_ADDIU  = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C, OP_ORI    = 6'h0D, OP_XORI = 6'h0E, OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_COP0    = 6'h10;
    localparam logic [5:0] OP_LB      = 6'h20, OP_LH     = 6'h21, OP_LW   = 6'h23, OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25, OP_SB     = 6'h28, OP_SH   = 6'h29, OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL   = 6'h02, FN_SRA  = 6'h03, FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06, FN_SRAV  = 6'h07, FN_JR   = 6'h08, FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MFHI = 6'h10, FN_MTHI  = 6'h11, FN_MFLO = 6'h12, FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_DIV  = 6'h1A, FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD  = 6'h20, FN_ADDU  = 6'h21, FN_SUB  = 6'h22, FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24, FN_OR    = 6'h25, FN_XOR  = 6'h26, FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A, FN_SLTU  = 6'h2B;

    localparam logic [4:0] RT_BLTZ = 5'h00, RT_BGEZ = 5'h01;
    localparam logic [4:0] RS_MFC0 = 5'h00, RS_MTC0 = 5'h04;

    localparam logic [3:0] CL_NOP   = 4'd0, CL_ALU_R = 4'd1, CL_ALU_I = 4'd2, CL_LOAD = 4'd3;
    localparam logic [3:0] CL_STORE = 4'd4, CL_BRANCH = 4'd5, CL_JUMP = 4'd6, CL_MULDIV = 4'd7;
    localparam logic [3:0] CL_HILO  = 4'd8, CL_COP0  = 4'd9, CL_ERET  = 4'd10, CL_RI   = 4'd15;

    logic [5:0] dop, dfn;
    logic [4:0] drs, drt;
    logic [3:0] dec_cls;
    logic       dec_rs, dec_rt;

    assign dop = bus.in_instr[31:26];
    assign drs = bus.in_instr[25:21];
    assign drt = bus.in_instr[20:16];
    assign dfn = bus.in_instr[5:0];

    always_comb begin
        dec_cls = CL_RI;
        dec_rs  = 1'b0;
        dec_rt  = 1'b0;
        // Exact-word matches first so the all-zero sll never reaches the ALU_R decode.
        if (bus.in_instr == '0) begin
            dec_cls = CL_NOP;
        end else if (bus.in_instr == ERET_WORD) begin
            dec_cls = CL_ERET;
        end else begin
            case (dop)
                OP_SPECIAL: begin
                    case (dfn)
                        FN_SLL, FN_SRL, FN_SRA: begin
                            dec_cls = CL_ALU_R; dec_rt = 1'b1;
                        end
                        FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
                        FN_SLT, FN_SLTU, FN_SLLV, FN_SRLV, FN_SRAV: begin
                            dec_cls = CL_ALU_R; dec_rs = 1'b1; dec_rt = 1'b1;
                        end
                        FN_JR, FN_JALR: begin
                            dec_cls = CL_JUMP; dec_rs = 1'b1;
                        end
                        FN_MFHI, FN_MFLO: dec_cls = CL_HILO;
                        FN_MTHI, FN_MTLO: begin
                            dec_cls = CL_HILO; dec_rs = 1'b1;
                        end
                        FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                            dec_cls = CL_MULDIV; dec_rs = 1'b1; dec_rt = 1'b1;
                        end
                        default: ;
                    endcase
                end
                OP_REGIMM: begin
                    if (drt == RT_BLTZ || drt == RT_BGEZ) begin
                        dec_cls = CL_BRANCH; dec_rs = 1'b1;
                    end
                end
                OP_J, OP_JAL: dec_cls = CL_JUMP;
                OP_BEQ, OP_BNE: begin
                    dec_cls = CL_BRANCH; dec_rs = 1'b1; dec_rt = 1'b1;
                end
                OP_BLEZ, OP_BGTZ: begin
                    dec_cls = CL_BRANCH; dec_rs = 1'b1;
                end
                OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
                    dec_cls = CL_ALU_I; dec_rs = 1'b1;
                end
                OP_LUI: dec_cls = CL_ALU_I;
                OP_COP0: begin
                    if (drs == RS_MFC0) begin
                        dec_cls = CL_COP0;
                    end else if (drs == RS_MTC0) begin
                        dec_cls = CL_COP0; dec_rt = 1'b1;
                    end
                end
                OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                    dec_cls = CL_LOAD; dec_rs = 1'b1;
                end
                OP_SB, OP_SH, OP_SW: begin
                    dec_cls = CL_STORE; dec_rs = 1'b1; dec_rt = 1'b1;
                end
                default: ;
            endcase
        end
    end

    logic [31:0]     mem_instr [DEPTH];
    logic [PC_W-1:0] mem_pc    [DEPTH];
    logic [3:0]      mem_cls   [DEPTH];
    logic            mem_rs    [DEPTH];
    logic            mem_rt    [DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             full, empty, enq, deq;
    logic [3:0]       head_cls;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign enq   = bus.in_valid && !full;
    assign deq   = bus.out_ready && !empty;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
            if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
            if (enq && !deq)      count <= count + CNT_W'(1);
            else if (!enq && deq) count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            mem_instr[wr_ptr] <= bus.in_instr;
            mem_pc[wr_ptr]    <= bus.in_pc;
            mem_cls[wr_ptr]   <= dec_cls;
            mem_rs[wr_ptr]    <= dec_rs;
            mem_rt[wr_ptr]    <= dec_rt;
        end
    end

    assign head_cls       = mem_cls[rd_ptr];
    assign bus.in_ready   = !full;
    assign bus.out_valid  = !empty;
    assign bus.out_instr  = empty ? '0 : mem_instr[rd_ptr];
    assign bus.out_pc     = empty ? '0 : mem_pc[rd_ptr];
    assign bus.out_class  = empty ? '0 : CLASS_W'(head_cls);
    assign bus.out_ri     = !empty && (head_cls == CL_RI);
    assign bus.out_use_rs = !empty && mem_rs[rd_ptr];
    assign bus.out_use_rt = !empty && mem_rt[rd_ptr];

`ifdef DECODE_QUEUE_RI_STATS_EN
    logic [31:0] ri_cnt_q;

    // Flush wins over a same-cycle dequeue, so a flushed RI head is not counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            ri_cnt_q <= '0;
        end else if (deq && !flush && bus.out_ri && ri_cnt_q != '1) begin
            ri_cnt_q <= ri_cnt_q + 32'd1;
        end
    end

    assign ri_count = ri_cnt_q;
`else
    assign ri_count = '0;
`endif
endmodule

// File: tb/tb_decode_queue.sv
// Randomised self-checking bench for decode_queue against a queue-based reference model.
module tb_decode_queue;
    localparam int DEPTH   = 4;
    localparam int PC_W    = 32;
    localparam int CLASS_W = 4;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        int          cls;
        bit          urs;
        bit          urt;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    logic [$clog2(DEPTH):0] count;
    logic [31:0] ri_count;

    decode_queue_if #(.PC_W(PC_W), .CLASS_W(CLASS_W)) bus ();

    decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .CLASS_W(CLASS_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .bus      (bus),
        .count    (count),
        .ri_count (ri_count)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    ent_t        q[$];
    logic [31:0] ri_model = '0;

    logic [5:0] fn_tab [0:23] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
                                  6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B,
                                  6'h20, 6'h23, 6'h27, 6'h2A, 6'h2B, 6'h01, 6'h0C, 6'h3F};
    logic [5:0] op_tab [0:23] = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09,
                                  6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h21,
                                  6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h22, 6'h3F};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void ref_decode(input logic [31:0] w, output int cls, output bit urs, output bit urt);
        logic [5:0] op, fn;
        logic [4:0] rsf, rtf;
        op = w[31:26]; fn = w[5:0]; rsf = w[25:21]; rtf = w[20:16];
        cls = 15; urs = 0; urt = 0;
        if (w == 32'h0) cls = 0;
        else if (w == 32'h4200_0018) cls = 10;
        else if (op == 6'h00) begin
            if (fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
                           6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07}) begin
                cls = 1; urt = 1; urs = !(fn inside {6'h00, 6'h02, 6'h03});
            end else if (fn inside {6'h08, 6'h09}) begin
                cls = 6; urs = 1;
            end else if (fn inside {[6'h18:6'h1B]}) begin
                cls = 7; urs = 1; urt = 1;
            end else if (fn inside {[6'h10:6'h13]}) begin
                cls = 8; urs = (fn == 6'h11 || fn == 6'h13);
            end
        end
        else if (op inside {[6'h08:6'h0F]}) begin cls = 2; urs = (op != 6'h0F); end
        else if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) begin cls = 3; urs = 1; end
        else if (op inside {6'h28, 6'h29, 6'h2B}) begin cls = 4; urs = 1; urt = 1; end
        else if (op inside {[6'h04:6'h07]}) begin cls = 5; urs = 1; urt = (op <= 6'h05); end
        else if (op == 6'h01 && rtf <= 5'd1) begin cls = 5; urs = 1; end
        else if (op inside {6'h02, 6'h03}) cls = 6;
        else if (op == 6'h10 && (rsf == 5'd0 || rsf == 5'd4)) begin cls = 9; urt = (rsf == 5'd4); end
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0] cop_rs [0:3];
        cop_rs = '{5'h00, 5'h04, 5'h10, 5'h01};
        case ($urandom_range(0, 7))
            0: return $urandom;
            1: return {6'h00, 20'($urandom), fn_tab[$urandom_range(0, 23)]};
            2: return {op_tab[$urandom_range(0, 23)], 26'($urandom)};
            3: return {6'h01, 5'($urandom), 5'($urandom_range(0, 3)), 16'($urandom)};
            4: return {6'h10, cop_rs[$urandom_range(0, 3)], 21'($urandom)};
            5: return 32'h4200_0018;
            6: return 32'h0;
            default: return {6'h00, 20'($urandom_range(0, 3)), 6'h00};
        endcase
    endfunction

    task automatic check_outputs();
        logic [31:0] exp_ri;
`ifdef DECODE_QUEUE_RI_STATS_EN
        exp_ri = ri_model;
`else
        exp_ri = '0;
`endif
        check("count", count, q.size());
        check("in_ready", bus.in_ready, q.size() < DEPTH);
        check("out_valid", bus.out_valid, q.size() > 0);
        check("ri_count", ri_count, exp_ri);
        if (q.size() == 0) begin
            check("out_instr_empty", bus.out_instr, 0);
            check("out_pc_empty", bus.out_pc, 0);
            check("out_class_empty", bus.out_class, 0);
            check("out_ri_empty", bus.out_ri, 0);
            check("use_rs_empty", bus.out_use_rs, 0);
            check("use_rt_empty", bus.out_use_rt, 0);
        end else begin
            check("out_instr", bus.out_instr, q[0].instr);
            check("out_pc", bus.out_pc, q[0].pc);
            check("out_class", bus.out_class, q[0].cls);
            check("out_ri", bus.out_ri, q[0].cls == 15);
            check("use_rs", bus.out_use_rs, q[0].urs);
            check("use_rt", bus.out_use_rt, q[0].urt);
        end
    endtask

    // One clock: drive at negedge, check settled state, then advance the model at posedge.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic ordy, input logic fl, input logic rst);
        bit   do_enq, do_deq;
        ent_t e;
        @(negedge clk);
        bus.in_valid = v; bus.in_instr = ins; bus.in_pc = pc;
        bus.out_ready = ordy; flush = fl; reset = rst;
        #1;
        check_outputs();
        do_enq = v && (q.size() < DEPTH);
        do_deq = ordy && (q.size() > 0);
        @(posedge clk);
        if (rst) begin
            q.delete(); ri_model = '0;
        end else if (fl) begin
            q.delete();
        end else begin
            if (do_deq) begin
                e = q.pop_front();
                if (e.cls == 15 && ri_model != 32'hFFFF_FFFF) ri_model = ri_model + 1;
            end
            if (do_enq) begin
                e.instr = ins; e.pc = pc;
                ref_decode(ins, e.cls, e.urs, e.urt);
                q.push_back(e);
            end
        end
    endtask

    initial begin
        logic [31:0] words [0:3];
        int          cls_exp [0:3];
        words   = '{32'h0000_0000, 32'h0232_8020, 32'h8C08_0004, 32'h4200_0018};
        cls_exp = '{0, 1, 3, 10};

        reset = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        step(0, 0, 0, 0, 0, 1);
        #1;
        check("rst_count", count, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_ri_count", ri_count, 0);

        for (int i = 0; i < 4; i++) step(1, words[i], 32'h1000 + 32'(4 * i), 0, 0, 0);
        #1;
        check("p1_count_full", count, 4);
        check("p1_in_ready_full", bus.in_ready, 0);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("p1_class", bus.out_class, cls_exp[i]);
            check("p1_pc", bus.out_pc, 32'h1000 + 32'(4 * i));
            step(0, 0, 0, 1, 0, 0);
        end

        for (int i = 0; i < 4; i++) step(1, 32'h2442_0001, 32'h1100 + 32'(4 * i), 0, 0, 0);
        step(1, 32'h2442_0002, 32'h1200, 1, 0, 0);
        #1;
        check("full_deq_no_enq", count, 3);
        repeat (3) step(0, 0, 0, 1, 0, 0);

        step(1, 32'h0008_4080, 32'h2000, 0, 0, 0);
        #1;
        check("sll_class", bus.out_class, 1);
        check("sll_rs", bus.out_use_rs, 0);
        check("sll_rt", bus.out_use_rt, 1);
        step(1, 32'h3C01_1234, 32'h2004, 1, 0, 0);
        #1;
        check("lui_class", bus.out_class, 2);
        check("lui_rs", bus.out_use_rs, 0);
        check("lui_rt", bus.out_use_rt, 0);
        step(0, 0, 0, 1, 0, 0);

        step(1, 32'hFC00_0000, 32'h3000, 0, 0, 0);
        #1;
        check("ri_class", bus.out_class, 15);
        check("ri_flag", bus.out_ri, 1);
        step(0, 0, 0, 1, 0, 0);
        #1;
`ifdef DECODE_QUEUE_RI_STATS_EN
        check("ri_count_one", ri_count, 1);
`else
        check("ri_count_tied", ri_count, 0);
`endif

        step(1, 32'h0232_8020, 32'h4000, 0, 0, 0);
        step(1, 32'h8C08_0004, 32'h4004, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(1, rand_instr(), 32'h4008 + 32'(4 * i), 1, 0, 0);
        #1;
        check("steady_count", count, 2);

        step(1, 32'h0232_8020, 32'h5000, 0, 0, 0);
        #1;
        check("pre_flush_count", count, 3);
        step(1, 32'h8C08_0004, 32'h5004, 1, 1, 0);
        #1;
        check("flush_count", count, 0);
        check("flush_out_valid", bus.out_valid, 0);
        check("flush_in_ready", bus.in_ready, 1);

        for (int i = 0; i < 4; i++) step(1, 32'hFC00_0000, 32'h6000 + 32'(4 * i), 0, 0, 0);
        step(1, 32'h0232_8020, 32'h6100, 1, 0, 1);
        #1;
        check("reset_full_count", count, 0);
        check("reset_full_valid", bus.out_valid, 0);
        check("reset_full_ri", ri_count, 0);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 7, rand_instr(), $urandom, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 31) == 0, $urandom_range(0, 255) == 0);
        end
        step(0, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
